genius_fluxo_dados: RTL and testbench

GENIUS_FLUXO_DADOS -- requirements
Module: genius_fluxo_dados

---
 rtl/genius_pkg.sv | 28 ++
 rtl/genius_contador_m.sv | 32 +++
 rtl/genius_fluxo_dados.sv | 154 +++++++++++++++
 tb/tb_genius_fluxo_dados.sv | 276 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/genius_pkg.sv
// Shared constants for the Genius datapath: colour codes, LED source
// encodings and the contents of both sequence ROM banks.
package genius_pkg;

   typedef logic [3:0] cor_t;

   // One-hot colour codes, bit i = colour i
   localparam cor_t COR_VERDE    = 4'b0001;
   localparam cor_t COR_VERMELHO = 4'b0010;
   localparam cor_t COR_AZUL     = 4'b0100;
   localparam cor_t COR_AMARELO  = 4'b1000;

   // LED source select encodings
   localparam logic [1:0] LEDS_APAGADOS = 2'b00;
   localparam logic [1:0] LEDS_MEMORIA  = 2'b01;
   localparam logic [1:0] LEDS_BOTOES   = 2'b10;

   // Bank0 entry k = one-hot(k mod 4); nibble k sits at bits [4k+3:4k]
   localparam logic [15:0][3:0] ROM_BANCO0 = 64'h8421_8421_8421_8421;
   // Bank1 entry k = one-hot(3 - (k mod 4)), the mirrored sequence
   localparam logic [15:0][3:0] ROM_BANCO1 = 64'h1248_1248_1248_1248;

   // Colour index to one-hot code
   function automatic cor_t cor_one_hot(input logic [1:0] indice);
      return cor_t'(4'b0001 << indice);
   endfunction

endpackage

// File: rtl/genius_contador_m.sv
// Generic modulo-N counter with clear/increment strobes and flags for the
// half-way point (N/2-1) and the final value (N-1). Clear wins over count.
module genius_contador_m #(
   parameter int MODULO  = 16,
   parameter int LARGURA = (MODULO > 1) ? $clog2(MODULO) : 1
) (
   input  logic               clock,
   input  logic               reset,
   input  logic               zera,
   input  logic               conta,
   output logic [LARGURA-1:0] contagem,
   output logic               meio,
   output logic               fim
);

   localparam logic [LARGURA-1:0] ULTIMO = LARGURA'(MODULO - 1);
   localparam logic [LARGURA-1:0] METADE = LARGURA'(MODULO / 2 - 1);

   // Count register: async reset, clear dominates, wrap after the last value
   always_ff @(posedge clock or posedge reset) begin
      if (reset)
         contagem <= '0;
      else if (zera)
         contagem <= '0;
      else if (conta)
         contagem <= (contagem == ULTIMO) ? '0 : contagem + LARGURA'(1);
   end

   assign meio = (contagem == METADE);
   assign fim  = (contagem == ULTIMO);

endmodule

// File: rtl/genius_fluxo_dados.sv
// Genius game datapath: address (E), limit (L) and display (M) counters,
// move register (R), button edge detector, per-move timeout counter (T),
// sequence ROM and LED source multiplexer.
// Optional second sequence bank: define GENIUS_SEGUNDA_MEMORIA_EN to let
// seletorMemoria choose between bank0 and bank1; otherwise bank0 only.
module genius_fluxo_dados
   import genius_pkg::*;
#(
   parameter int MOSTRA_CICLOS  = 1000,
   parameter int TIMEOUT_CICLOS = 5000
) (
   input  logic       clock,
   input  logic       reset,
   input  logic [3:0] botoes,
   input  logic       zeraE,
   input  logic       contaE,
   input  logic       zeraL,
   input  logic       contaL,
   input  logic       zeraM,
   input  logic       contaM,
   input  logic       zeraR,
   input  logic       registraR,
   input  logic       contaT,
   input  logic [1:0] seletor,
   input  logic       seletorMemoria,
   output logic       jogada,
   output logic       timeout,
   output logic       botoesIgualMemoria,
   output logic       fimE,
   output logic       fimL,
   output logic       meioL,
   output logic       enderecoIgualLimite,
   output logic       enderecoMenorLimite,
   output logic       fimM,
   output logic       meioM,
   output logic [3:0] leds,
   output logic [3:0] db_contagem,
   output logic [3:0] db_limite,
   output logic [3:0] db_jogada
);

   localparam int LARGURA_T = (TIMEOUT_CICLOS > 1) ? $clog2(TIMEOUT_CICLOS) : 1;
   localparam int LARGURA_M = (MOSTRA_CICLOS > 1) ? $clog2(MOSTRA_CICLOS) : 1;
   localparam logic [LARGURA_T-1:0] T_MAX = LARGURA_T'(TIMEOUT_CICLOS - 1);

   logic [3:0]           endereco;
   logic [3:0]           limite;
   logic [3:0]           jogada_reg;
   logic [3:0]           memoria;
   logic [LARGURA_T-1:0] contagem_t;
   logic                 botao_anterior;
   logic                 meio_e_unused;
   logic [LARGURA_M-1:0] contagem_m_unused;

   // Address counter E: walks the sequence memory
   genius_contador_m #(.MODULO(16)) contador_e (
      .clock    (clock),
      .reset    (reset),
      .zera     (zeraE),
      .conta    (contaE),
      .contagem (endereco),
      .meio     (meio_e_unused),
      .fim      (fimE)
   );

   // Limit counter L: length of the sequence played so far
   genius_contador_m #(.MODULO(16)) contador_l (
      .clock    (clock),
      .reset    (reset),
      .zera     (zeraL),
      .conta    (contaL),
      .contagem (limite),
      .meio     (meioL),
      .fim      (fimL)
   );

   // Display timer M: paces how long each colour is shown
   genius_contador_m #(.MODULO(MOSTRA_CICLOS)) contador_m (
      .clock    (clock),
      .reset    (reset),
      .zera     (zeraM),
      .conta    (contaM),
      .contagem (contagem_m_unused),
      .meio     (meioM),
      .fim      (fimM)
   );

   // Move register R: captures the pressed buttons
   always_ff @(posedge clock or posedge reset) begin
      if (reset)
         jogada_reg <= 4'b0000;
      else if (zeraR)
         jogada_reg <= 4'b0000;
      else if (registraR)
         jogada_reg <= botoes;
   end

   // Edge-detector history: was any button down in the previous cycle
   always_ff @(posedge clock or posedge reset) begin
      if (reset)
         botao_anterior <= 1'b0;
      else
         botao_anterior <= |botoes;
   end

   // A move is the first cycle with any button down after an idle cycle
   assign jogada = (|botoes) & ~botao_anterior;

   // Timeout counter T: saturates, restarts when disabled or on a move
   always_ff @(posedge clock or posedge reset) begin
      if (reset)
         contagem_t <= '0;
      else if (!contaT || jogada)
         contagem_t <= '0;
      else if (contagem_t != T_MAX)
         contagem_t <= contagem_t + LARGURA_T'(1);
   end

   assign timeout = contaT && (contagem_t == T_MAX);

`ifdef GENIUS_SEGUNDA_MEMORIA_EN
   // Sequence ROM, asynchronous read, bank chosen at run time
   always_comb begin
      memoria = seletorMemoria ? ROM_BANCO1[endereco] : ROM_BANCO0[endereco];
   end
`else
   logic seletor_memoria_unused;
   assign seletor_memoria_unused = seletorMemoria;

   // Sequence ROM, asynchronous read, single bank
   always_comb begin
      memoria = ROM_BANCO0[endereco];
   end
`endif

   assign botoesIgualMemoria  = (jogada_reg == memoria);
   assign enderecoIgualLimite = (endereco == limite);
   assign enderecoMenorLimite = (endereco < limite);

   // LED source multiplexer
   always_comb begin
      leds = 4'b0000;
      case (seletor)
         LEDS_MEMORIA: leds = memoria;
         LEDS_BOTOES:  leds = botoes;
         default:      leds = 4'b0000;
      endcase
   end

   assign db_contagem = endereco;
   assign db_limite   = limite;
   assign db_jogada   = jogada_reg;

endmodule

// File: tb/tb_genius_fluxo_dados.sv
// Directed bench for genius_fluxo_dados with small timer periods. A
// behavioural model follows the counting rules and is compared against every
// output on each falling edge; directed literal checks pin the model.
// GENIUS_SEGUNDA_MEMORIA_EN selects the expected bank behaviour.
module tb_genius_fluxo_dados;

   localparam int MC = 8;
   localparam int TC = 8;

   logic       clock;
   logic       reset;
   logic [3:0] botoes;
   logic       zeraE, contaE, zeraL, contaL, zeraM, contaM;
   logic       zeraR, registraR, contaT;
   logic [1:0] seletor;
   logic       seletorMemoria;
   logic       jogada, timeout, botoesIgualMemoria, fimE, fimL, meioL;
   logic       enderecoIgualLimite, enderecoMenorLimite, fimM, meioM;
   logic [3:0] leds, db_contagem, db_limite, db_jogada;

   int n_assert = 0;
   int n_fail   = 0;

   genius_fluxo_dados #(.MOSTRA_CICLOS(MC), .TIMEOUT_CICLOS(TC)) dut (
      .clock               (clock),
      .reset               (reset),
      .botoes              (botoes),
      .zeraE               (zeraE),
      .contaE              (contaE),
      .zeraL               (zeraL),
      .contaL              (contaL),
      .zeraM               (zeraM),
      .contaM              (contaM),
      .zeraR               (zeraR),
      .registraR           (registraR),
      .contaT              (contaT),
      .seletor             (seletor),
      .seletorMemoria      (seletorMemoria),
      .jogada              (jogada),
      .timeout             (timeout),
      .botoesIgualMemoria  (botoesIgualMemoria),
      .fimE                (fimE),
      .fimL                (fimL),
      .meioL               (meioL),
      .enderecoIgualLimite (enderecoIgualLimite),
      .enderecoMenorLimite (enderecoMenorLimite),
      .fimM                (fimM),
      .meioM               (meioM),
      .leds                (leds),
      .db_contagem         (db_contagem),
      .db_limite           (db_limite),
      .db_jogada           (db_jogada)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   task automatic check(input string nome, input logic [31:0] atual, input logic [31:0] esperado);
      n_assert++;
      if (atual !== esperado) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at %0t", nome, atual, esperado, $time);
      end
   endtask

   // ---------------- behavioural model ----------------
   int       me, ml, mm, mt;
   bit [3:0] mr;
   bit       m_prev;

   function automatic bit exp_jogada();
      return (botoes != 4'b0000) && !m_prev;
   endfunction

   function automatic logic [3:0] exp_mem();
      int k;
      k = me % 4;
`ifdef GENIUS_SEGUNDA_MEMORIA_EN
      if (seletorMemoria) return 4'(8 >> k);
`endif
      return 4'(1 << k);
   endfunction

   always @(posedge clock or posedge reset) begin
      if (reset) begin
         me <= 0; ml <= 0; mm <= 0; mt <= 0; mr <= 4'b0000; m_prev <= 1'b0;
      end else begin
         me <= zeraE ? 0 : (contaE ? (me + 1) % 16 : me);
         ml <= zeraL ? 0 : (contaL ? (ml + 1) % 16 : ml);
         mm <= zeraM ? 0 : (contaM ? (mm + 1) % MC : mm);
         mt <= (!contaT || exp_jogada()) ? 0 : ((mt + 1 > TC - 1) ? TC - 1 : mt + 1);
         mr <= zeraR ? 4'b0000 : (registraR ? botoes : mr);
         m_prev <= (botoes != 4'b0000);
      end
   end

   // Compare every output against the model away from the active edge
   always @(negedge clock) begin
      if (!reset) begin
         logic [3:0] exp_leds;
         exp_leds = (seletor == 2'b01) ? exp_mem() : ((seletor == 2'b10) ? botoes : 4'b0000);
         check("m_jogada", 32'(jogada), 32'(exp_jogada()));
         check("m_timeout", 32'(timeout), 32'(contaT && (mt == TC - 1)));
         check("m_igual_mem", 32'(botoesIgualMemoria), 32'(mr == exp_mem()));
         check("m_fimE", 32'(fimE), 32'(me == 15));
         check("m_fimL", 32'(fimL), 32'(ml == 15));
         check("m_meioL", 32'(meioL), 32'(ml == 7));
         check("m_end_igual", 32'(enderecoIgualLimite), 32'(me == ml));
         check("m_end_menor", 32'(enderecoMenorLimite), 32'(me < ml));
         check("m_fimM", 32'(fimM), 32'(mm == MC - 1));
         check("m_meioM", 32'(meioM), 32'(mm == MC / 2 - 1));
         check("m_leds", 32'(leds), 32'(exp_leds));
         check("m_db_contagem", 32'(db_contagem), 32'(me));
         check("m_db_limite", 32'(db_limite), 32'(ml));
         check("m_db_jogada", 32'(db_jogada), 32'(mr));
      end
   end

   // Advance n clock edges, landing just after the edge
   task automatic step(input int n);
      repeat (n) begin
         @(posedge clock);
         #1;
      end
   endtask

   // Safety net so the run always ends
   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog expired");
   end

   // ---------------- directed stimulus ----------------
   initial begin
      int pulsos;
      botoes = 4'b0000;
      zeraE = 0; contaE = 0; zeraL = 0; contaL = 0; zeraM = 0; contaM = 0;
      zeraR = 0; registraR = 0; contaT = 0;
      seletor = 2'b00; seletorMemoria = 1'b0;
      reset = 1'b1;
      repeat (2) @(posedge clock);
      #1 reset = 1'b0;
      #1;
      check("rst_db_contagem", 32'(db_contagem), 32'd0);
      check("rst_db_limite", 32'(db_limite), 32'd0);
      check("rst_db_jogada", 32'(db_jogada), 32'd0);
      check("rst_jogada", 32'(jogada), 32'd0);
      check("rst_timeout", 32'(timeout), 32'd0);
      check("rst_igual", 32'(enderecoIgualLimite), 32'd1);
      check("rst_menor", 32'(enderecoMenorLimite), 32'd0);
      check("rst_leds", 32'(leds), 32'd0);

      // Address counter, three increments then clear-with-count
      contaE = 1;
      step(3);
      contaE = 0;
      #1;
      check("e_after3", 32'(db_contagem), 32'd3);
      check("e_igual", 32'(enderecoIgualLimite), 32'd0);
      check("e_menor", 32'(enderecoMenorLimite), 32'd0);
      zeraE = 1; contaE = 1;
      step(1);
      zeraE = 0; contaE = 0;
      #1;
      check("e_zera_dom", 32'(db_contagem), 32'd0);

      // One press held for ten cycles gives a single move pulse
      botoes = 4'b0010;
      pulsos = 0;
      for (int i = 0; i < 10; i++) begin
         #1;
         if (jogada) pulsos++;
         @(posedge clock);
         #1;
      end
      check("jogada_pulsos", 32'(pulsos), 32'd1);
      registraR = 1;
      step(1);
      registraR = 0; contaE = 1;
      step(1);
      contaE = 0;
      seletor = 2'b10;
      #1;
      check("r_loaded", 32'(db_jogada), 32'h2);
      check("r_addr", 32'(db_contagem), 32'd1);
      check("r_igual_mem", 32'(botoesIgualMemoria), 32'd1);
      check("leds_botoes", 32'(leds), 32'h2);
      seletor = 2'b00;
      botoes = 4'b0000;
      step(1);

      // Timeout: rises on the 8th enabled cycle and stays up
      contaT = 1;
      for (int k = 1; k <= 10; k++) begin
         #1;
         check($sformatf("timeout_k%0d", k), 32'(timeout), 32'(k >= 8));
         step(1);
      end
      botoes = 4'b0100;
      #1;
      check("press_jogada", 32'(jogada), 32'd1);
      step(1);
      #1;
      check("timeout_cleared", 32'(timeout), 32'd0);
      contaT = 0;
      botoes = 4'b0000;
      step(1);

      // Display timer flags over more than one period
      contaM = 1;
      for (int k = 0; k < 12; k++) begin
         #1;
         check($sformatf("meioM_k%0d", k), 32'(meioM), 32'((k % 8) == 3));
         check($sformatf("fimM_k%0d", k), 32'(fimM), 32'((k % 8) == 7));
         step(1);
      end
      contaM = 0;

      // Memory bank selection on the LEDs at address 0
      zeraE = 1;
      step(1);
      zeraE = 0;
      seletor = 2'b01; seletorMemoria = 1'b1;
      #1;
`ifdef GENIUS_SEGUNDA_MEMORIA_EN
      check("leds_banco", 32'(leds), 32'h8);
`else
      check("leds_banco", 32'(leds), 32'h1);
`endif
      seletor = 2'b11;
      #1;
      check("leds_sel11", 32'(leds), 32'h0);
      seletor = 2'b00; seletorMemoria = 1'b0;
      step(1);

      // Limit counter through a full wrap
      contaL = 1;
      for (int k = 0; k <= 16; k++) begin
         #1;
         check($sformatf("limite_k%0d", k), 32'(db_limite), 32'(k % 16));
         check($sformatf("fimL_k%0d", k), 32'(fimL), 32'(k == 15));
         check($sformatf("meioL_k%0d", k), 32'(meioL), 32'(k == 7));
         step(1);
      end
      contaL = 0;

      // Reset in the middle of counting
      contaE = 1; contaL = 1; contaM = 1; contaT = 1;
      botoes = 4'b0001; registraR = 1;
      step(5);
      check("pre_rst_e", 32'(db_contagem), 32'd5);
      check("pre_rst_r", 32'(db_jogada), 32'h1);
      #2 reset = 1'b1;
      #1;
      check("async_rst_e", 32'(db_contagem), 32'd0);
      check("async_rst_l", 32'(db_limite), 32'd1 - 32'd1);
      check("async_rst_r", 32'(db_jogada), 32'd0);
      check("async_rst_timeout", 32'(timeout), 32'd0);
      @(posedge clock);
      #1 reset = 1'b0;
      #1;
      check("rel_e", 32'(db_contagem), 32'd0);
      step(1);
      #1;
      check("resume_e", 32'(db_contagem), 32'd1);
      check("resume_l", 32'(db_limite), 32'd1);
      contaE = 0; contaL = 0; contaM = 0; contaT = 0; registraR = 0;
      botoes = 4'b0000;
      step(2);

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule
